// File: rtl/m6809_pkg.sv
// Shared types and sizing helpers for the 6809E clock/reset conditioner.
package m6809_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } rst_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/m6809_clkrst_if.sv
// Board-side signals of the 6809E clock/reset conditioner.
interface m6809_clkrst_if;

  logic rst_btn_b;
  logic stretch_req;
  logic eclk;
  logic qclk;
  logic e_fall;
  logic cpu_reset_b;
  logic btn_db_b;
  logic stretching;

  modport master (
    input  rst_btn_b, stretch_req,
    output eclk, qclk, e_fall, cpu_reset_b, btn_db_b, stretching
  );

  modport slave (
    output rst_btn_b, stretch_req,
    input  eclk, qclk, e_fall, cpu_reset_b, btn_db_b, stretching
  );

endinterface

// File: rtl/m6809_debounce.sv
// Two-flop synchroniser plus saturating debounce counter for an active-low switch.
module m6809_debounce #(
  parameter int unsigned DB_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_raw,
  output logic level_db
);

  logic               sync1;
  logic               sync2;
  logic [DB_BITS-1:0] cnt;

  // Level must differ from the debounced value for 2**DB_BITS cycles to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      cnt      <= '0;
      level_db <= 1'b1;
    end else begin
      sync1 <= level_raw;
      sync2 <= sync1;
      if (sync2 == level_db) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        level_db <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + DB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/m6809_clkrst_gen.sv
// Quadrature E/Q generator with per-cycle E stretch and conditioned CPU reset
// for 6809E cards.
module m6809_clkrst_gen
  import m6809_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned DB_BITS  = 16,
  parameter int unsigned RST_ECYC = 64,
  parameter int unsigned WAIT_QP  = 4
) (
  input  logic clk,
  input  logic rst_n,
  m6809_clkrst_if.master bus
);

  localparam bit          STR_EN  = (WAIT_QP != 0);
  localparam int unsigned STR_LEN = WAIT_QP * DIV;
  localparam int unsigned QW      = cnt_width(DIV - 1);
  localparam int unsigned SW      = cnt_width(STR_EN ? STR_LEN - 1 : 0);
  localparam int unsigned EW      = cnt_width(RST_ECYC - 1);

  localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STR_EN ? STR_LEN - 1 : 0);
  localparam logic [EW-1:0] E_LAST = EW'(RST_ECYC - 1);

  phase_e         phase, phase_nx;
  logic [QW-1:0]  qcnt, qcnt_nx;
  logic [SW-1:0]  scnt, scnt_nx;
  logic           str_lat, str_lat_nx;
  logic           str_q, str_nx;
  logic           eclk_q, qclk_q, e_fall_q;
  logic           eclk_nx, qclk_nx, e_fall_nx;

  rst_state_e     rs, rs_nx;
  logic [EW-1:0]  ecnt, ecnt_nx;
  logic           cpu_reset_b_q;
  logic           btn_db;

  m6809_debounce #(.DB_BITS(DB_BITS)) u_btn_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .level_raw (bus.rst_btn_b),
    .level_db  (btn_db)
  );

  // Phase FSM state and registered clock outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH0;
      qcnt     <= '0;
      scnt     <= '0;
      str_lat  <= 1'b0;
      str_q    <= 1'b0;
      eclk_q   <= 1'b0;
      qclk_q   <= 1'b0;
      e_fall_q <= 1'b0;
    end else begin
      phase    <= phase_nx;
      qcnt     <= qcnt_nx;
      scnt     <= scnt_nx;
      str_lat  <= str_lat_nx;
      str_q    <= str_nx;
      eclk_q   <= eclk_nx;
      qclk_q   <= qclk_nx;
      e_fall_q <= e_fall_nx;
    end
  end

  // Quarter-phase sequencing; the stretch is inserted at the tail of PH2.
  always_comb begin
    phase_nx   = phase;
    qcnt_nx    = qcnt + QW'(1);
    scnt_nx    = scnt;
    str_lat_nx = str_lat;
    str_nx     = str_q;
    if (str_q) begin
      qcnt_nx = '0;
      if (scnt == S_LAST) begin
        str_nx   = 1'b0;
        scnt_nx  = '0;
        phase_nx = PH3;
      end else begin
        scnt_nx = scnt + SW'(1);
      end
    end else if (qcnt == Q_LAST) begin
      qcnt_nx = '0;
      case (phase)
        PH0: begin
          phase_nx   = PH1;
          str_lat_nx = bus.stretch_req;
        end
        PH1: phase_nx = PH2;
        PH2: begin
          if (STR_EN && str_lat) begin
            str_nx  = 1'b1;
            scnt_nx = '0;
          end else begin
            phase_nx = PH3;
          end
        end
        PH3:     phase_nx = PH0;
        default: phase_nx = PH0;
      endcase
    end
    eclk_nx   = (phase_nx == PH2) || (phase_nx == PH3);
    qclk_nx   = (phase_nx == PH1) || (phase_nx == PH2);
    e_fall_nx = (phase == PH3) && (phase_nx == PH0);
  end

  // Reset FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs            <= COUNT;
      ecnt          <= '0;
      cpu_reset_b_q <= 1'b0;
    end else begin
      rs            <= rs_nx;
      ecnt          <= ecnt_nx;
      cpu_reset_b_q <= (rs_nx == RUN);
    end
  end

  // Counts E falls using the pre-register strobe so release lands on the ECLK fall edge.
  always_comb begin
    rs_nx   = rs;
    ecnt_nx = ecnt;
    case (rs)
      HOLD: begin
        if (btn_db) begin
          rs_nx   = COUNT;
          ecnt_nx = '0;
        end
      end
      COUNT: begin
        if (!btn_db) begin
          rs_nx   = HOLD;
          ecnt_nx = '0;
        end else if (e_fall_nx) begin
          if (ecnt == E_LAST) begin
            rs_nx   = RUN;
            ecnt_nx = '0;
          end else begin
            ecnt_nx = ecnt + EW'(1);
          end
        end
      end
      RUN: begin
        if (!btn_db) begin
          rs_nx   = HOLD;
          ecnt_nx = '0;
        end
      end
      default: begin
        rs_nx   = HOLD;
        ecnt_nx = '0;
      end
    endcase
  end

  assign bus.eclk        = eclk_q;
  assign bus.qclk        = qclk_q;
  assign bus.e_fall      = e_fall_q;
  assign bus.cpu_reset_b = cpu_reset_b_q;
  assign bus.btn_db_b    = btn_db;
  assign bus.stretching  = str_q;

endmodule

// File: tb/tb_m6809_clkrst_gen.sv
// Directed bench for m6809_clkrst_gen: free-running phases, stretch, button
// debounce/reset sequencing, async reset mid-stretch, and a no-stretch build.
module tb_m6809_clkrst_gen;

  localparam int DIV      = 2;
  localparam int DB_BITS  = 3;
  localparam int RST_ECYC = 4;
  localparam int WAIT_QP  = 2;
  localparam int EPER     = 4 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int w0_err = 0;
  int w0_str = 0;

  m6809_clkrst_if bus ();
  m6809_clkrst_if bus0 ();

  m6809_clkrst_gen #(
    .DIV(DIV), .DB_BITS(DB_BITS), .RST_ECYC(RST_ECYC), .WAIT_QP(WAIT_QP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  m6809_clkrst_gen #(
    .DIV(DIV), .DB_BITS(DB_BITS), .RST_ECYC(RST_ECYC), .WAIT_QP(0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Unstretched waveform, counted in CLK edges since reset release.
  function automatic logic exp_e(input int c);
    return ((c / DIV) % 4) >= 2;
  endfunction

  function automatic logic exp_q(input int c);
    int p;
    p = (c / DIV) % 4;
    return (p == 1) || (p == 2);
  endfunction

  function automatic logic exp_f(input int c);
    return (c > 0) && ((c % EPER) == 0);
  endfunction

  // Advance to the next sample point; the no-stretch build is tracked every cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus0.eclk !== exp_e(cyc)) w0_err++;
    if (bus0.stretching !== 1'b0) w0_str++;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("eclk@%0d", cyc), bus.eclk, exp_e(cyc));
      check($sformatf("qclk@%0d", cyc), bus.qclk, exp_q(cyc));
      check($sformatf("e_fall@%0d", cyc), bus.e_fall, exp_f(cyc));
      check($sformatf("cpu_rst@%0d", cyc), bus.cpu_reset_b, cyc >= RST_ECYC * EPER);
    end
  endtask

  // Called on the sample where BTN_DB_B has just risen.
  task automatic count_to_release(input string tag, input int exp_falls);
    int  falls;
    bit  done;
    falls = 0;
    done  = 1'b0;
    step();
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (bus.e_fall) falls++;
      if (bus.cpu_reset_b) begin
        done = 1'b1;
        check({tag, "_on_efall"}, bus.e_fall, 1);
      end
    end
    check({tag, "_released"}, done, 1);
    check({tag, "_falls"}, falls, exp_falls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e_hi, s_hi, s_first, f1, f2, falls, s0;
    bit  rose, found;

    bus.rst_btn_b   = 1'b1;
    bus.stretch_req = 1'b0;
    bus0.rst_btn_b  = 1'b1;
    bus0.stretch_req = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_eclk", bus.eclk, 0);
    check("rst_qclk", bus.qclk, 0);
    check("rst_e_fall", bus.e_fall, 0);
    check("rst_cpu", bus.cpu_reset_b, 0);
    check("rst_btn_db", bus.btn_db_b, 1);
    check("rst_stretching", bus.stretching, 0);

    // Release with no button: 8-cycle E, CPU reset released on the 4th fall.
    rst_n = 1'b1;
    cyc   = 0;
    run_free(40);

    // Stretch request sampled at the PH1 entry edge (cycle 42).
    step();
    bus.stretch_req = 1'b1;
    step();
    bus.stretch_req = 1'b0;
    e_hi = 0; s_hi = 0; s_first = 0; f1 = 0; f2 = 0;
    while (cyc < 62) begin
      step();
      if (bus.eclk && f1 == 0) e_hi++;
      if (bus.stretching) s_hi++;
      if (bus.stretching && s_first == 0) s_first = cyc;
      if (bus.e_fall) begin
        if (f1 == 0) f1 = cyc;
        else if (f2 == 0) f2 = cyc;
      end
      if (cyc == 49) check("str_qclk_hi@49", bus.qclk, 1);
      if (cyc == 50) check("str_qclk_lo@50", bus.qclk, 0);
    end
    check("str_e_high", e_hi, 8);
    check("str_count", s_hi, 4);
    check("str_first", s_first, 46);
    check("str_fall", f1, 52);
    check("str_next_period", f2 - f1, EPER);

    // Bouncy press, then stable low.
    for (int b = 0; b < 2; b++) begin
      bus.rst_btn_b = 1'b0;
      repeat (3) step();
      bus.rst_btn_b = 1'b1;
      repeat (3) step();
    end
    check("bounce_db", bus.btn_db_b, 1);
    bus.rst_btn_b = 1'b0;
    s0 = cyc;
    repeat (9) step();
    check("db_hold@9", bus.btn_db_b, 1);
    step();
    check("db_fall@10", bus.btn_db_b, 0);
    check("cpu_still_hi@10", bus.cpu_reset_b, 1);
    step();
    check("cpu_fall@11", bus.cpu_reset_b, 0);
    check("press_len", cyc - s0, 11);
    repeat (2) step();
    bus.rst_btn_b = 1'b1;
    repeat (9) step();
    check("db_rel_hold@9", bus.btn_db_b, 0);
    step();
    check("db_rise@10", bus.btn_db_b, 1);
    count_to_release("rel1", RST_ECYC);

    // Press, release, re-press after two E falls of counting.
    bus.rst_btn_b = 1'b0;
    repeat (12) step();
    check("t4_hold", bus.cpu_reset_b, 0);
    bus.rst_btn_b = 1'b1;
    repeat (10) step();
    check("t4_db_rise", bus.btn_db_b, 1);
    step();
    falls = 0;
    rose  = 1'b0;
    for (int i = 0; i < 100 && falls < 2; i++) begin
      step();
      if (bus.e_fall) falls++;
      if (bus.cpu_reset_b) rose = 1'b1;
    end
    check("t4_two_falls", falls, 2);
    bus.rst_btn_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.cpu_reset_b) rose = 1'b1;
    end
    check("t4_no_rise", rose, 0);
    bus.rst_btn_b = 1'b1;
    repeat (10) step();
    check("t4_db_rise2", bus.btn_db_b, 1);
    count_to_release("rel2", RST_ECYC);

    // Async reset in the middle of a stretched PH2.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.e_fall) found = 1'b1;
    end
    check("t5_found_fall", found, 1);
    bus.stretch_req = 1'b1;
    repeat (2) step();
    bus.stretch_req = 1'b0;
    repeat (5) step();
    check("t5_pre_str", bus.stretching, 1);
    check("t5_pre_eclk", bus.eclk, 1);
    check("t5_pre_cpu", bus.cpu_reset_b, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_eclk", bus.eclk, 0);
    check("t5_qclk", bus.qclk, 0);
    check("t5_str", bus.stretching, 0);
    check("t5_cpu", bus.cpu_reset_b, 0);
    check("t5_btn_db", bus.btn_db_b, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_free(40);

    check("w0_period", w0_err, 0);
    check("w0_stretching", w0_str, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
